// File: rtl/cart_bankswitch.sv
// Cartridge-side responder for the 6507 ROM port.
// Maps the 4 KB CPU window into a multi-bank cartridge image using F8/F6/F4
// hotspot bank switching, with optional 128-byte Superchip RAM at $000-$0FF
// of the window (write port $000-$07F, read port $080-$0FF).
module cart_bankswitch #(
  parameter int NUM_BANKS = 2,  // 1 = plain 4K, 2 = F8, 4 = F6, 8 = F4
  parameter int SC_RAM    = 0   // 1 = Superchip RAM present
) (
  input  logic        CLOCKBUS,
  input  logic        RES,
  input  logic        ROM_CS,
  input  logic [11:0] ROM_Addr,
  input  logic        ROM_RW_n,
  input  logic [7:0]  CPU_Dout,
  output logic [7:0]  ROM_Dout,
  output logic [14:0] IMG_Addr,
  input  logic [7:0]  IMG_Dout,
  output logic [2:0]  BANK
);

  // Highest bank is selected out of reset so the reset vector comes from it.
  localparam logic [2:0]  BANK_RST = 3'(NUM_BANKS - 1);
  localparam logic [11:0] HS_BASE  = (NUM_BANKS == 8) ? 12'hFF4 :
                                     (NUM_BANKS == 4) ? 12'hFF6 : 12'hFF8;
  localparam logic [11:0] HS_LAST  = HS_BASE + 12'(NUM_BANKS - 1);
  localparam bit          HAS_HS   = (NUM_BANKS > 1);
  localparam bit          HAS_SC   = (SC_RAM != 0);

  logic       hs_hit;
  logic [2:0] hs_k;
  logic       sc_wr_win;
  logic       sc_rd_win;
  logic       ram_we;
  logic [7:0] ram_q;
  logic [7:0] ram [128];

  // Hotspot decode; the bank index only needs the low three address bits
  // because the hotspot window never spans more than eight addresses.
  assign hs_hit = HAS_HS && ROM_CS && (ROM_Addr >= HS_BASE) && (ROM_Addr <= HS_LAST);
  assign hs_k   = ROM_Addr[2:0] - HS_BASE[2:0];

  // Superchip windows are decoded from the window address only, so they are
  // the same in every bank.
  assign sc_wr_win = HAS_SC && ROM_CS && (ROM_Addr[11:7] == 5'b00000);
  assign sc_rd_win = HAS_SC && ROM_CS && (ROM_Addr[11:7] == 5'b00001);

  // The real Superchip has no R/W_n decode: reads of the write port also
  // latch whatever is on the data bus, so both bus directions write.
  assign ram_we = sc_wr_win && (ROM_RW_n || !ROM_RW_n);

  assign IMG_Addr = {BANK, ROM_Addr};
  assign ram_q    = ram[ROM_Addr[6:0]];

  // Bank register: reset wins over a hotspot hit in the same cycle.
  always_ff @(posedge CLOCKBUS) begin
    if (RES) begin
      BANK <= BANK_RST;
    end else if (hs_hit) begin
      BANK <= hs_k;
    end
  end

  // Superchip RAM: contents are not reset-controlled, so a write during reset still lands.
  always_ff @(posedge CLOCKBUS) begin
    if (ram_we) begin
      ram[ROM_Addr[6:0]] <= CPU_Dout;
    end
  end

  // Read-data mux: deselected bus, RAM write port, RAM read port, then image.
  always_comb begin
    ROM_Dout = IMG_Dout;
    if (!ROM_CS) begin
      ROM_Dout = 8'h00;
    end else if (sc_wr_win) begin
      ROM_Dout = 8'hFF;
    end else if (sc_rd_win) begin
      ROM_Dout = ram_q;
    end
  end

endmodule
